serial_subtractor: RTL

Bit-serial N-bit subtractor computing diff = a − b LSB-first, one bit per clock, through a single registered full-subtractor cell (difference = x ⊕ y ⊕ bin, borrow-out = ~x·y + ~(x ⊕ y)·bin). It is the inverse-direction counterpart of the team's full-adder cells, built as a sequential datapath block. It sits between an operand source that pulses `start` and a consumer that waits for `done`.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 110 +++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between the operand source, the bit-serial subtractor and its consumer.
// The master side drives start/a/b and observes busy/done/diff/borrow.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor step per clock; done pulses WIDTH cycles after start is accepted.
// No backpressure: start is only sampled in IDLE, and requests in RUN/DONE are dropped.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  sub
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             bin_q,    bin_d;
  logic             borrow_q, borrow_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic x_bit, y_bit, d_bit, bout;

  // Single full-subtractor cell fed from the bottom of the operand shift registers.
  assign x_bit = a_sr_q[0];
  assign y_bit = b_sr_q[0];
  assign d_bit = x_bit ^ y_bit ^ bin_q;
  assign bout  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & bin_q);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sub.start) begin
          a_sr_d  = sub.a;
          b_sr_d  = sub.b;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // Difference bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        bin_d  = bout;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          borrow_d = bout;
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sub.busy   = busy_q;
  assign sub.done   = done_q;
  assign sub.diff   = diff_q;
  assign sub.borrow = borrow_q;

endmodule
